// File: rtl/fp_cmp_prep_if.sv
// Handshake bundle between the operand source, fp_cmp_prep and the min/max select.
// master: the side that drives operations in and accepts results.
// slave : fp_cmp_prep itself.
interface fp_cmp_prep_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data1;
  logic [63:0]      in_data2;
  logic [1:0]       in_fmt;
  logic [2:0]       in_rm;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data1;
  logic [63:0]      out_data2;
  logic [64:0]      out_ext1;
  logic [64:0]      out_ext2;
  logic [9:0]       out_class1;
  logic [9:0]       out_class2;
  logic [1:0]       out_fmt;
  logic [2:0]       out_rm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data1, in_data2, in_fmt, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_data1, out_data2, out_ext1, out_ext2,
           out_class1, out_class2, out_fmt, out_rm, out_tag
  );

  modport slave (
    input  in_valid, in_data1, in_data2, in_fmt, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_data1, out_data2, out_ext1, out_ext2,
           out_class1, out_class2, out_fmt, out_rm, out_tag
  );
endinterface

// File: rtl/fp_cmp_prep.sv
// fp_cmp_prep: two-stage operand preparation for the FP min/max unit.
// S1 captures raw operands; S2 holds fclass one-hot and sign/magnitude
// extended forms. Optional build macro FP_NANBOX_CHECK_EN treats a single
// precision operand whose upper word is not all ones as a canonical quiet NaN.
module fp_cmp_prep #(
  parameter int TAG_W = 4
) (
  input logic           clock,
  input logic           reset,
  input logic           flush,
  fp_cmp_prep_if.slave  bus
);

  // fclass one-hot: bit0 -inf .. bit7 +inf, bit8 sNaN, bit9 qNaN
  function automatic logic [9:0] f_class(input logic [63:0] data, input logic [1:0] fmt);
    logic       sign;
    logic       exp_ones;
    logic       exp_zero;
    logic       mant_zero;
    logic       mant_msb;
    logic [9:0] cls;
    if (fmt == 2'd0) begin
      sign      = data[31];
      exp_ones  = &data[30:23];
      exp_zero  = ~|data[30:23];
      mant_zero = ~|data[22:0];
      mant_msb  = data[22];
    end else begin
      sign      = data[63];
      exp_ones  = &data[62:52];
      exp_zero  = ~|data[62:52];
      mant_zero = ~|data[51:0];
      mant_msb  = data[51];
    end
    if (exp_ones && !mant_zero)     cls = mant_msb ? 10'h200 : 10'h100;
    else if (exp_ones)              cls = sign ? 10'h001 : 10'h080;
    else if (exp_zero && mant_zero) cls = sign ? 10'h008 : 10'h010;
    else if (exp_zero)              cls = sign ? 10'h004 : 10'h020;
    else                            cls = sign ? 10'h002 : 10'h040;
`ifdef FP_NANBOX_CHECK_EN
    if (fmt == 2'd0 && data[63:32] != 32'hFFFF_FFFF) cls = 10'h200;
`endif
    return cls;
  endfunction

  // Sign on top, magnitude below, so an unsigned compare of [63:0] orders magnitudes
  function automatic logic [64:0] f_ext(input logic [63:0] data, input logic [1:0] fmt);
    logic [64:0] ext;
    if (fmt == 2'd0) ext = {data[31], 33'b0, data[30:0]};
    else             ext = {data[63], 1'b0, data[62:0]};
`ifdef FP_NANBOX_CHECK_EN
    // Improperly boxed singles become the canonical qNaN 32'h7FC00000
    if (fmt == 2'd0 && data[63:32] != 32'hFFFF_FFFF) ext = {1'b0, 33'b0, 31'h7FC0_0000};
`endif
    return ext;
  endfunction

  logic             r_s1_valid;
  logic [63:0]      r_s1_data1;
  logic [63:0]      r_s1_data2;
  logic [1:0]       r_s1_fmt;
  logic [2:0]       r_s1_rm;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [63:0]      r_s2_data1;
  logic [63:0]      r_s2_data2;
  logic [64:0]      r_s2_ext1;
  logic [64:0]      r_s2_ext2;
  logic [9:0]       r_s2_class1;
  logic [9:0]       r_s2_class2;
  logic [1:0]       r_s2_fmt;
  logic [2:0]       r_s2_rm;
  logic [TAG_W-1:0] r_s2_tag;

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_fire;
  logic w_s1_move;

  assign w_s2_adv  = !r_s2_valid || bus.out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_in_fire = bus.in_valid && w_s1_adv;
  assign w_s1_move = r_s1_valid && w_s2_adv;

  assign bus.in_ready = w_s1_adv;

  // Stage valid bits; flush wins over any same-cycle transfer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= bus.in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  // S1 datapath: raw operand capture on input transfer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_data1 <= '0;
      r_s1_data2 <= '0;
      r_s1_fmt   <= '0;
      r_s1_rm    <= '0;
      r_s1_tag   <= '0;
    end else if (w_in_fire) begin
      r_s1_data1 <= bus.in_data1;
      r_s1_data2 <= bus.in_data2;
      r_s1_fmt   <= bus.in_fmt;
      r_s1_rm    <= bus.in_rm;
      r_s1_tag   <= bus.in_tag;
    end
  end

  // S2 datapath: classification and extension of the S1 operands
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s2_data1  <= '0;
      r_s2_data2  <= '0;
      r_s2_ext1   <= '0;
      r_s2_ext2   <= '0;
      r_s2_class1 <= '0;
      r_s2_class2 <= '0;
      r_s2_fmt    <= '0;
      r_s2_rm     <= '0;
      r_s2_tag    <= '0;
    end else if (w_s1_move) begin
      r_s2_data1  <= r_s1_data1;
      r_s2_data2  <= r_s1_data2;
      r_s2_ext1   <= f_ext(r_s1_data1, r_s1_fmt);
      r_s2_ext2   <= f_ext(r_s1_data2, r_s1_fmt);
      r_s2_class1 <= f_class(r_s1_data1, r_s1_fmt);
      r_s2_class2 <= f_class(r_s1_data2, r_s1_fmt);
      r_s2_fmt    <= r_s1_fmt;
      r_s2_rm     <= r_s1_rm;
      r_s2_tag    <= r_s1_tag;
    end
  end

  assign bus.out_valid  = r_s2_valid;
  assign bus.out_data1  = r_s2_data1;
  assign bus.out_data2  = r_s2_data2;
  assign bus.out_ext1   = r_s2_ext1;
  assign bus.out_ext2   = r_s2_ext2;
  assign bus.out_class1 = r_s2_class1;
  assign bus.out_class2 = r_s2_class2;
  assign bus.out_fmt    = r_s2_fmt;
  assign bus.out_rm     = r_s2_rm;
  assign bus.out_tag    = r_s2_tag;

endmodule

// File: tb/tb_fp_cmp_prep.sv
// Scoreboard bench for fp_cmp_prep: the driver pushes expected bundles on each
// accepted input, the monitor pops and compares on each output transfer.
module tb_fp_cmp_prep;
  localparam int TAG_W = 4;

  typedef struct {
    logic [63:0]      d1;
    logic [63:0]      d2;
    logic [64:0]      e1;
    logic [64:0]      e2;
    logic [9:0]       c1;
    logic [9:0]       c2;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  fp_cmp_prep_if #(.TAG_W(TAG_W)) bus ();

  fp_cmp_prep #(.TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(input string nm, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Reference model, from the field rules with plain arithmetic
  function automatic bit boxed_bad(input logic [63:0] d, input logic [1:0] fmt);
`ifdef FP_NANBOX_CHECK_EN
    return (fmt == 2'd0) && ((d >> 32) != 64'hFFFF_FFFF);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [9:0] ref_class(input logic [63:0] d, input logic [1:0] fmt);
    longint unsigned e, m, emax, q;
    bit s;
    int idx;
    if (boxed_bad(d, fmt)) return 10'h200;
    if (fmt == 2'd0) begin
      s = d[31]; e = (d >> 23) & 64'hFF; m = d & 64'h7F_FFFF; emax = 255; q = (m >> 22) & 1;
    end else begin
      s = d[63]; e = (d >> 52) & 64'h7FF; m = d & ((64'd1 << 52) - 1); emax = 2047; q = (m >> 51) & 1;
    end
    if (e == emax)   idx = (m != 0) ? ((q != 0) ? 9 : 8) : (s ? 0 : 7);
    else if (e == 0) idx = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    else             idx = s ? 1 : 6;
    return 10'd1 << idx;
  endfunction

  function automatic logic [64:0] ref_ext(input logic [63:0] d, input logic [1:0] fmt);
    logic [64:0] r;
    if (boxed_bad(d, fmt))  r = {1'b0, 64'h7FC0_0000};
    else if (fmt == 2'd0)   r = {d[31], d & 64'h7FFF_FFFF};
    else                    r = {d[63], d & 64'h7FFF_FFFF_FFFF_FFFF};
    return r;
  endfunction

  function automatic exp_t mk(input logic [63:0] d1, input logic [63:0] d2, input logic [1:0] fmt,
                              input logic [2:0] rm, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.d1 = d1; e.d2 = d2; e.fmt = fmt; e.rm = rm; e.tag = tag;
    e.c1 = ref_class(d1, fmt); e.c2 = ref_class(d2, fmt);
    e.e1 = ref_ext(d1, fmt);   e.e2 = ref_ext(d2, fmt);
    return e;
  endfunction

  function automatic exp_t mk_fixed(input logic [63:0] d1, input logic [63:0] d2, input logic [1:0] fmt,
                                    input logic [2:0] rm, input logic [TAG_W-1:0] tag,
                                    input logic [9:0] c1, input logic [9:0] c2,
                                    input logic [64:0] e1, input logic [64:0] e2);
    exp_t e;
    e.d1 = d1; e.d2 = d2; e.fmt = fmt; e.rm = rm; e.tag = tag;
    e.c1 = c1; e.c2 = c2; e.e1 = e1; e.e2 = e2;
    return e;
  endfunction

  function automatic logic [63:0] rnd_op(input bit single);
    int unsigned ek = $urandom_range(0, 3);
    int unsigned mk_ = $urandom_range(0, 2);
    longint unsigned s = $urandom_range(0, 1);
    longint unsigned e, m, hi;
    if (single) begin
      e = (ek == 0) ? 0 : (ek == 1) ? 255 : $urandom_range(1, 254);
      m = (mk_ == 0) ? 0 : (mk_ == 1) ? ($urandom & 32'h7F_FFFF) : ($urandom & 32'h3F_FFFF);
      hi = ($urandom_range(0, 7) == 0) ? 64'($urandom) : 64'hFFFF_FFFF;
      return (hi << 32) | (s << 31) | (e << 23) | m;
    end else begin
      e = (ek == 0) ? 0 : (ek == 1) ? 2047 : $urandom_range(1, 2046);
      m = ((64'($urandom) << 32) | 64'($urandom)) & ((64'd1 << 52) - 1);
      if (mk_ == 0) m = 0;
      else if (mk_ == 2) m = m & ((64'd1 << 51) - 1);
      return (s << 63) | (e << 52) | m;
    end
  endfunction

  function automatic exp_t rnd_exp();
    logic [1:0] fmt = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
    return mk(rnd_op(fmt == 2'd0), rnd_op(fmt == 2'd0), fmt, 3'($urandom), TAG_W'($urandom));
  endfunction

  // Monitor: compares each output transfer against the scoreboard head
  bit               held = 0;
  logic [63:0]      h_d1;
  logic [64:0]      h_e1;
  logic [9:0]       h_c2;
  logic [TAG_W-1:0] h_tag;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      held = 0;
    end else begin
      if (held && bus.out_valid) begin
        chk("hold_data1", 65'(bus.out_data1), 65'(h_d1));
        chk("hold_ext1", bus.out_ext1, h_e1);
        chk("hold_class2", 65'(bus.out_class2), 65'(h_c2));
        chk("hold_tag", 65'(bus.out_tag), 65'(h_tag));
      end
      if (bus.out_valid && bus.out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("unexpected_output_tag", 65'(bus.out_tag), 65'h1_FFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_tag", 65'(bus.out_tag), 65'(e.tag));
          chk("out_data1", 65'(bus.out_data1), 65'(e.d1));
          chk("out_data2", 65'(bus.out_data2), 65'(e.d2));
          chk("out_ext1", bus.out_ext1, e.e1);
          chk("out_ext2", bus.out_ext2, e.e2);
          chk("out_class1", 65'(bus.out_class1), 65'(e.c1));
          chk("out_class2", 65'(bus.out_class2), 65'(e.c2));
          chk("out_fmt", 65'(bus.out_fmt), 65'(e.fmt));
          chk("out_rm", 65'(bus.out_rm), 65'(e.rm));
        end
      end
      held  = bus.out_valid && !bus.out_ready && !flush;
      h_d1  = bus.out_data1;
      h_e1  = bus.out_ext1;
      h_c2  = bus.out_class2;
      h_tag = bus.out_tag;
    end
  end

  // One cycle of stimulus; entered and left at posedge+1
  task automatic step(input bit v, input exp_t e, input bit ordy, input bit fl, output bit acc);
    bus.in_valid  = v;
    bus.in_data1  = e.d1;
    bus.in_data2  = e.d2;
    bus.in_fmt    = e.fmt;
    bus.in_rm     = e.rm;
    bus.in_tag    = e.tag;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clock);
    acc = v && bus.in_ready && !fl;
    if (acc) sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic send(input exp_t e, input bit ordy);
    bit acc = 0;
    for (int n = 0; n < 50 && !acc; n++) step(1, e, ordy, 0, acc);
    if (!acc) chk("send_timeout_accepted", 65'(acc), 65'd1);
  endtask

  task automatic drain();
    bit   acc;
    exp_t z = mk(64'd0, 64'd0, 2'd1, 3'd0, '0);
    for (int n = 0; n < 100 && sb.size() != 0; n++) step(0, z, 1, 0, acc);
    chk("drain_pending", 65'(sb.size()), 65'd0);
    step(0, z, 1, 0, acc);
  endtask

  initial begin
    bit   acc;
    int   tagn;
    exp_t z;
    z = mk(64'd0, 64'd0, 2'd1, 3'd0, '0);
    bus.in_valid = 0; bus.in_data1 = '0; bus.in_data2 = '0; bus.in_fmt = '0;
    bus.in_rm = '0; bus.in_tag = '0; bus.out_ready = 0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 65'(bus.out_valid), 65'd0);
    chk("rst_in_ready", 65'(bus.in_ready), 65'd1);
    chk("rst_out_ext1", bus.out_ext1, 65'd0);
    chk("rst_out_class1", 65'(bus.out_class1), 65'd0);
    reset = 1'b1;

    // Directed vectors with hand-derived expectations
    send(mk_fixed(64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 2'd0, 3'd1, 4'd1,
                  10'h040, 10'h002, {1'b0, 64'h3F80_0000}, {1'b1, 64'h3F80_0000}), 1);
    send(mk_fixed(64'h7FF4_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd1, 3'd2, 4'd2,
                  10'h100, 10'h008, {1'b0, 64'h7FF4_0000_0000_0000}, {1'b1, 64'd0}), 1);
    send(mk_fixed(64'h0000_0000_7FC0_0000, 64'hFFFF_FFFF_0000_0000, 2'd0, 3'd3, 4'd3,
                  10'h200, 10'h010, {1'b0, 64'h7FC0_0000}, 65'd0), 1);
`ifdef FP_NANBOX_CHECK_EN
    send(mk_fixed(64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_7F80_0000, 2'd0, 3'd4, 4'd4,
                  10'h200, 10'h080, {1'b0, 64'h7FC0_0000}, {1'b0, 64'h7F80_0000}), 1);
`else
    send(mk_fixed(64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_7F80_0000, 2'd0, 3'd4, 4'd4,
                  10'h040, 10'h080, {1'b0, 64'h3F80_0000}, {1'b0, 64'h7F80_0000}), 1);
`endif
    drain();

    // Stream tags 1..5 with downstream stalled for the first five cycles
    tagn = 1;
    for (int cyc = 0; cyc < 40 && tagn <= 5; cyc++) begin
      step(1, mk(rnd_op(1), rnd_op(1), 2'd0, 3'd0, TAG_W'(tagn)), cyc >= 5, 0, acc);
      if (cyc < 5) chk("stream_accept", 65'(acc), 65'(cyc < 2));
      if (acc) tagn++;
    end
    chk("stream_all_sent", 65'(tagn), 65'd6);
    drain();

    // Flush with two ops in flight and a same-cycle input attempt
    send(rnd_exp(), 0);
    send(rnd_exp(), 0);
    step(1, rnd_exp(), 0, 1, acc);
    sb.delete();
    chk("flush_out_valid", 65'(bus.out_valid), 65'd0);
    chk("flush_in_ready", 65'(bus.in_ready), 65'd1);
    repeat (3) step(0, z, 1, 0, acc);
    chk("flush_nothing_emerged", 65'(bus.out_valid), 65'd0);

    // Asynchronous reset between clock edges with two ops in flight
    send(rnd_exp(), 0);
    send(rnd_exp(), 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 65'(bus.out_valid), 65'd0);
    chk("arst_in_ready", 65'(bus.in_ready), 65'd1);
    chk("arst_out_data1", 65'(bus.out_data1), 65'd0);
    chk("arst_out_tag", 65'(bus.out_tag), 65'd0);
    sb.delete();
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) step(0, z, 1, 0, acc);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 800; n++)
      step($urandom_range(0, 3) != 0, rnd_exp(), $urandom_range(0, 3) != 0, 0, acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_cmp_prep.md
# fp_cmp_prep

Pipelined operand-preparation stage that feeds the floating-point min/max unit. It accepts two raw operands plus format and rounding-mode fields and classifies each operand into the 10-bit fclass one-hot vector. It also builds the 65-bit sign/magnitude extended form used for ordering. It presents the result, registered, with valid/ready handshakes on both sides, so the combinational min/max select can consume `data1/data2/ext1/ext2/fmt/rm/class1/class2` directly.

## Interface
- `TAG_W`, default 4: width of the opaque tag carried alongside each operation.
- `reset`  in  1  asynchronous, active-low reset.
- `clock`  in  1  single clock; all state on rising edge.
- `flush`  in  1  synchronous; drops all in-flight operations.
- `in_valid`  in  1  input operation valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data1`, `in_data2`  in  64  raw operands; single precision is NaN-boxed in bits [31:0].
- `in_fmt`  in  2  0 = single; any other value = double.
- `in_rm`  in  3  passed through unchanged (selects min/max downstream).
- `in_tag`  in  TAG_W  passed through unchanged.
- `out_valid`  out  1  output bundle valid.
- `out_ready`  in  1  downstream accepts.
- `out_data1`, `out_data2`  out  64  operands as received.
- `out_ext1`, `out_ext2`  out  65  extended operands.
- `out_class1`, `out_class2`  out  10  fclass one-hot.
- `out_fmt`  out  2  registered format field.
- `out_rm`  out  3  registered rounding-mode field.
- `out_tag`  out  TAG_W  registered tag.

## Operation
- Two-stage pipeline.
  - S1 registers the raw inputs.
  - S2 registers the classification and extension computed from S1.
- Each stage has its own valid bit.
- Class bit assignments, exactly one set per operand:
  - 0 = −inf, 1 = −normal, 2 = −subnormal, 3 = −zero
  - 4 = +zero, 5 = +subnormal, 6 = +normal, 7 = +inf
  - 8 = signaling NaN, 9 = quiet NaN
- Single-precision field decode: exp = [30:23], mant = [22:0], sign = [31].
- Double-precision field decode: exp = [62:52], mant = [51:0], sign = [63].
- Classification rules:
  - exp all-ones with mant ≠ 0 is a NaN.
  - The mantissa MSB selects quiet (1) or signaling (0).
- Extended form:
  - `ext[64]` = sign.
  - Single: `ext[63:0]` = {33'b0, data[30:0]}.
  - Double: `ext[63:0]` = {1'b0, data[62:0]}.
  - Unsigned compare of `ext[63:0]` therefore orders magnitudes.
- Data, fmt, rm and tag pass through bit-exact.

## Timing
- Latency is 2 cycles from input handshake to `out_valid` when there is no backpressure.
- Throughput is 1 operation per cycle.
- Stage advance rules:
  - `s2_adv` = !s2_valid | out_ready.
  - `s1_adv` = !s1_valid | s2_adv.
  - `in_ready` = `s1_adv`, purely combinational from state and `out_ready`. It does not depend on `in_valid`.
- Input transfer occurs on `in_valid & in_ready`. Output transfer occurs on `out_valid & out_ready`.
- While `out_valid=1` and `out_ready=0`, every `out_*` field holds stable.
- When `out_ready` is held low, the pipeline fills to 2 entries and then `in_ready` falls. No entry is ever lost or duplicated.
- Simultaneous output transfer and input transfer on a full pipe is legal and keeps the pipe full.
- `flush=1` clears both valid bits at the next edge and overrides a same-cycle input transfer. The datapath registers are don't-care.
- Reset (asynchronous, mid-operation included) sets:
  - `s1_valid` = 0, `s2_valid` = 0, so `out_valid` = 0 and `in_ready` = 1.
  - All datapath registers, and therefore every other `out_*`, to 0.

## Configuration
- Macro `FP_NANBOX_CHECK_EN` enables NaN-box checking for single precision.
- Defined, with fmt = 0 and `data[63:32]` ≠ 32'hFFFFFFFF:
  - The operand is classified as quiet NaN (class = 10'h200).
  - Ext is built from 32'h7FC00000.
  - `out_data` still carries the raw value.
- Undefined: `data[63:32]` is ignored for fmt = 0.

## Test plan
- Single, data1 = 64'hFFFFFFFF_3F800000, data2 = 64'hFFFFFFFF_BF800000 → after 2 cycles:
  - class1 = 10'h040, class2 = 10'h002.
  - ext1 = {1'b0, 64'h3F800000}, ext2 = {1'b1, 64'h3F800000}.
- Double, data1 = 64'h7FF4000000000000 (sNaN), data2 = 64'h8000000000000000 (−0) → class1 = 10'h100, class2 = 10'h008.
- Single, data1 = 64'h00000000_7FC00000:
  - With `FP_NANBOX_CHECK_EN`: class1 = 10'h200.
  - Without it: class1 = 10'h200, the same class reached via decode.
- Single, data1 = 64'h00000000_3F800000:
  - With the macro: class1 = 10'h200.
  - Without: class1 = 10'h040.
- Stream 5 ops with tags 1..5 and `out_ready` low for cycles 2–6:
  - `in_ready` falls after 2 accepts.
  - Outputs then appear in tag order 1..5 with no loss.
- Assert `reset` low while 2 ops are in flight → `out_valid` = 0 immediately and `in_ready` = 1. A `flush` mid-stream likewise drops both in-flight tags.
